// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between fetch and decode.
//
// A DEPTH-entry circular queue that accepts up to WIDTH instructions per
// cycle from fetch, together with their branch-prediction metadata, and
// presents up to WIDTH of the oldest entries to decode. Each entry stores
// the GHR snapshot of the group it arrived in.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   flush            synchronous discard of all entries
//   enq_valid        per-lane valid from fetch (lane 0 oldest); only the
//                    contiguous valid prefix starting at lane 0 is accepted
//   enq_ready        room for a full WIDTH group (registered count only)
//   enq_inst/pred/branch/next_addr/target_addr  per-lane enqueue payload
//   enq_ghr          GHR snapshot shared by the whole enqueue group
//   deq_valid        per-lane valid towards decode
//   deq_ready        decode consumes every valid dequeue lane this cycle
//   deq_inst/pred/branch/next_addr/target_addr/ghr  per-lane dequeue payload
//   count            current occupancy
module fetch_queue #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int INST_W = 32,
  parameter int ADDR_W = 8,
  parameter int GHR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          enq_valid,
  output logic                      enq_ready,
  input  logic [WIDTH*INST_W-1:0]   enq_inst,
  input  logic [WIDTH-1:0]          enq_pred,
  input  logic [WIDTH-1:0]          enq_branch,
  input  logic [WIDTH*ADDR_W-1:0]   enq_next_addr,
  input  logic [WIDTH*ADDR_W-1:0]   enq_target_addr,
  input  logic [GHR_W-1:0]          enq_ghr,
  output logic [WIDTH-1:0]          deq_valid,
  input  logic                      deq_ready,
  output logic [WIDTH*INST_W-1:0]   deq_inst,
  output logic [WIDTH-1:0]          deq_pred,
  output logic [WIDTH-1:0]          deq_branch,
  output logic [WIDTH*ADDR_W-1:0]   deq_next_addr,
  output logic [WIDTH*ADDR_W-1:0]   deq_target_addr,
  output logic [WIDTH*GHR_W-1:0]    deq_ghr,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INST_W-1:0] inst_mem   [DEPTH];
  logic              pred_mem   [DEPTH];
  logic              branch_mem [DEPTH];
  logic [ADDR_W-1:0] next_mem   [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];
  logic [GHR_W-1:0]  ghr_mem    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;

  logic [CNT_W-1:0] enq_k;     // length of the valid prefix of enq_valid
  logic [CNT_W-1:0] deq_d;     // number of lanes shown to decode
  logic             enq_fire;
  logic             deq_fire;
  logic [PTR_W-1:0] wr_idx [WIDTH];
  logic [PTR_W-1:0] rd_idx [WIDTH];

  assign count     = count_q;
  assign enq_ready = (count_q <= CNT_W'(DEPTH - WIDTH));

  // Lanes after the first cleared valid bit are squashed by fetch, so only
  // the leading run of ones counts.
  always_comb begin
    logic stop;
    enq_k = '0;
    stop  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!stop && enq_valid[i]) enq_k = enq_k + CNT_W'(1);
      else                       stop  = 1'b1;
    end
  end

  assign deq_d    = (count_q < CNT_W'(WIDTH)) ? count_q : CNT_W'(WIDTH);
  assign enq_fire = !flush && enq_ready && (enq_k != '0);
  assign deq_fire = !flush && deq_ready && (deq_d != '0);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      wr_idx[i] = tail + PTR_W'(i);
      rd_idx[i] = head + PTR_W'(i);
    end
  end

  // Pointer and occupancy state. Enqueue uses the pre-dequeue count, so the
  // simultaneous case simply adds and subtracts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) tail <= tail + PTR_W'(enq_k);
      if (deq_fire) head <= head + PTR_W'(deq_d);
      count_q <= count_q + (enq_fire ? enq_k : '0) - (deq_fire ? deq_d : '0);
    end
  end

  // Storage: accepted lanes land compacted at tail, tail+1, ...
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        inst_mem[e]   <= '0;
        pred_mem[e]   <= 1'b0;
        branch_mem[e] <= 1'b0;
        next_mem[e]   <= '0;
        target_mem[e] <= '0;
        ghr_mem[e]    <= '0;
      end
    end else if (enq_fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (CNT_W'(i) < enq_k) begin
          inst_mem[wr_idx[i]]   <= enq_inst[i*INST_W +: INST_W];
          pred_mem[wr_idx[i]]   <= enq_pred[i];
          branch_mem[wr_idx[i]] <= enq_branch[i];
          next_mem[wr_idx[i]]   <= enq_next_addr[i*ADDR_W +: ADDR_W];
          target_mem[wr_idx[i]] <= enq_target_addr[i*ADDR_W +: ADDR_W];
          ghr_mem[wr_idx[i]]    <= enq_ghr;
        end
      end
    end
  end

  // Dequeue view: combinational from storage; lanes beyond the occupancy
  // are forced to zero so stale storage never leaks after a flush.
  always_comb begin
    deq_valid       = '0;
    deq_inst        = '0;
    deq_pred        = '0;
    deq_branch      = '0;
    deq_next_addr   = '0;
    deq_target_addr = '0;
    deq_ghr         = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (CNT_W'(j) < count_q) begin
        deq_valid[j]                      = 1'b1;
        deq_inst[j*INST_W +: INST_W]      = inst_mem[rd_idx[j]];
        deq_pred[j]                       = pred_mem[rd_idx[j]];
        deq_branch[j]                     = branch_mem[rd_idx[j]];
        deq_next_addr[j*ADDR_W +: ADDR_W] = next_mem[rd_idx[j]];
        deq_target_addr[j*ADDR_W +: ADDR_W] = target_mem[rd_idx[j]];
        deq_ghr[j*GHR_W +: GHR_W]         = ghr_mem[rd_idx[j]];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (WIDTH=2, DEPTH=8).
module tb_fetch_queue;

  localparam int WIDTH  = 2;
  localparam int DEPTH  = 8;
  localparam int INST_W = 32;
  localparam int ADDR_W = 8;
  localparam int GHR_W  = 5;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic [WIDTH-1:0]        enq_valid;
  logic                    enq_ready;
  logic [WIDTH*INST_W-1:0] enq_inst;
  logic [WIDTH-1:0]        enq_pred;
  logic [WIDTH-1:0]        enq_branch;
  logic [WIDTH*ADDR_W-1:0] enq_next_addr;
  logic [WIDTH*ADDR_W-1:0] enq_target_addr;
  logic [GHR_W-1:0]        enq_ghr;
  logic [WIDTH-1:0]        deq_valid;
  logic                    deq_ready;
  logic [WIDTH*INST_W-1:0] deq_inst;
  logic [WIDTH-1:0]        deq_pred;
  logic [WIDTH-1:0]        deq_branch;
  logic [WIDTH*ADDR_W-1:0] deq_next_addr;
  logic [WIDTH*ADDR_W-1:0] deq_target_addr;
  logic [WIDTH*GHR_W-1:0]  deq_ghr;
  logic [$clog2(DEPTH):0]  count;

  int tests;
  int failed;

  fetch_queue #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W), .GHR_W(GHR_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_inst(enq_inst),
    .enq_pred(enq_pred), .enq_branch(enq_branch), .enq_next_addr(enq_next_addr),
    .enq_target_addr(enq_target_addr), .enq_ghr(enq_ghr),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst),
    .deq_pred(deq_pred), .deq_branch(deq_branch), .deq_next_addr(deq_next_addr),
    .deq_target_addr(deq_target_addr), .deq_ghr(deq_ghr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Metadata is derived from the instruction word so every entry carries
  // distinct, recognisable sideband values.
  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [4:0] g);
    enq_valid       = v;
    enq_inst        = {i1, i0};
    enq_pred        = {i1[0], i0[0]};
    enq_branch      = {i1[3], i0[3]};
    enq_next_addr   = {i1[7:0] + 8'd1, i0[7:0] + 8'd1};
    enq_target_addr = {i1[7:0] ^ 8'hA5, i0[7:0] ^ 8'hA5};
    enq_ghr         = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b0;
    flush = 1'b0;
    deq_ready = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0);

    // Reset / idle
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_deq_inst", deq_inst, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Fill with deq_ready low
    drive(2'b11, 32'h100, 32'h101, 5'd1); step(); check("fill_cnt2", 64'(count), 64'd2);
    drive(2'b11, 32'h102, 32'h103, 5'd2); step(); check("fill_cnt4", 64'(count), 64'd4);
    drive(2'b11, 32'h104, 32'h105, 5'd3); step(); check("fill_cnt6", 64'(count), 64'd6);
    check("fill_ready6", 64'(enq_ready), 64'd1);
    drive(2'b11, 32'h106, 32'h107, 5'd4); step(); check("fill_cnt8", 64'(count), 64'd8);
    check("fill_ready8", 64'(enq_ready), 64'd0);
    drive(2'b11, 32'h1F0, 32'h1F1, 5'd9); step(); check("fill_ignored", 64'(count), 64'd8);
    check("fill_head", deq_inst, {32'h101, 32'h100});
    check("fill_deq_valid", 64'(deq_valid), 64'd3);

    // Drain and refill across the wrap point
    drive(2'b00, 32'h0, 32'h0, 5'd0); deq_ready = 1'b1;
    step(); check("wrap_cnt_a", 64'(count), 64'd6);
    check("wrap_inst_a", deq_inst, {32'h103, 32'h102});
    drive(2'b11, 32'h108, 32'h109, 5'd5);
    step(); check("wrap_cnt_b", 64'(count), 64'd6);
    check("wrap_inst_b", deq_inst, {32'h105, 32'h104});
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    step(); check("wrap_cnt_c", 64'(count), 64'd4);
    check("wrap_inst_c", deq_inst, {32'h107, 32'h106});
    check("wrap_ghr_c", 64'(deq_ghr), {54'd0, 5'd4, 5'd4});
    step(); check("wrap_cnt_d", 64'(count), 64'd2);
    check("wrap_inst_d", deq_inst, {32'h109, 32'h108});
    check("wrap_next", 64'(deq_next_addr), 64'h0A09);
    check("wrap_target", 64'(deq_target_addr), 64'hACAD);
    check("wrap_pred", 64'(deq_pred), 64'b10);
    check("wrap_branch", 64'(deq_branch), 64'b11);
    check("wrap_ghr", 64'(deq_ghr), {54'd0, 5'd5, 5'd5});
    step(); check("wrap_empty_cnt", 64'(count), 64'd0);
    check("wrap_empty_valid", 64'(deq_valid), 64'd0);
    check("wrap_empty_inst", deq_inst, 64'd0);
    deq_ready = 1'b0;

    // Partial groups and squashed lanes
    drive(2'b01, 32'h200, 32'h2FF, 5'd6); step(); check("part_cnt1", 64'(count), 64'd1);
    check("part_one_lane", 64'(deq_valid), 64'b01);
    drive(2'b10, 32'h2F0, 32'h2F1, 5'd9); step(); check("part_drop", 64'(count), 64'd1);
    drive(2'b11, 32'h210, 32'h211, 5'd7); step(); check("part_cnt3", 64'(count), 64'd3);
    check("part_order", deq_inst, {32'h210, 32'h200});
    check("part_ghr", 64'(deq_ghr), {54'd0, 5'd7, 5'd6});

    // Simultaneous enqueue and dequeue
    drive(2'b11, 32'h220, 32'h221, 5'd8); deq_ready = 1'b1;
    step(); check("sim_cnt", 64'(count), 64'd3);
    check("sim_head", deq_inst, {32'h220, 32'h211});
    deq_ready = 1'b0;
    drive(2'b11, 32'h230, 32'h231, 5'd8); step(); check("pre_flush_cnt", 64'(count), 64'd5);

    // Flush beats concurrent enqueue and dequeue
    flush = 1'b1; deq_ready = 1'b1;
    drive(2'b11, 32'h240, 32'h241, 5'd9);
    step(); check("flush_cnt", 64'(count), 64'd0);
    check("flush_valid", 64'(deq_valid), 64'd0);
    check("flush_inst", deq_inst, 64'd0);
    check("flush_ready", 64'(enq_ready), 64'd1);
    flush = 1'b0; deq_ready = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    step(); check("flush_stays", 64'(count), 64'd0);

    // No bypass: an empty queue shows nothing in the enqueue cycle
    drive(2'b11, 32'h300, 32'h301, 5'd9);
    #1 check("nobypass", 64'(deq_valid), 64'd0);
    step(); check("lat_valid", 64'(deq_valid), 64'b11);
    check("lat_inst", deq_inst, {32'h301, 32'h300});
    drive(2'b00, 32'h0, 32'h0, 5'd0);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1 check("arst_valid", 64'(deq_valid), 64'd0);
    check("arst_cnt", 64'(count), 64'd0);
    check("arst_inst", deq_inst, 64'd0);
    #1 rst = 1'b1;
    step(); check("arst_idle", 64'(count), 64'd0);
    drive(2'b11, 32'h400, 32'h401, 5'd3); step();
    check("arst_resume_cnt", 64'(count), 64'd2);
    check("arst_resume_inst", deq_inst, {32'h401, 32'h400});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
